// File: rtl/icmp_echo_ctrl.sv
// rtl/icmp_echo_ctrl.sv - ICMP echo reply sequencer between rx parser and tx engine
module icmp_echo_ctrl #(
    parameter logic [15:0] TX_TIMEOUT = 16'd5000,
    parameter int          DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rx_pkt_done,
    input  logic [15:0]           rx_byte_num,
    input  logic [15:0]           rx_icmp_id,
    input  logic [15:0]           rx_icmp_seq,
    input  logic                  rx_sum_valid,
    input  logic [31:0]           rx_data_sum,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic                  tx_start_en,
    output logic [15:0]           tx_byte_num,
    output logic [15:0]           tx_icmp_id,
    output logic [15:0]           tx_icmp_seq,
    output logic [15:0]           tx_checksum,
    output logic                  ctrl_busy,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [DROP_CNT_W-1:0] timeout_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FOLD1     = 3'd1;
    localparam logic [2:0] S_FOLD2     = 3'd2;
    localparam logic [2:0] S_WAIT_TX   = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    localparam logic [DROP_CNT_W-1:0] CNT_ONE = 1;
    localparam logic [DROP_CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]  state;

    // Pending slot: header seen, payload sum not yet arrived
    logic        p_valid;
    logic [15:0] p_len;
    logic [15:0] p_id;
    logic [15:0] p_seq;

    // Two-entry descriptor queue, entry = {len, id, seq, sum}
    logic [79:0] fifo_mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  fifo_cnt;
    logic [79:0] fifo_head;

    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        push_ok;
    logic        drop_inc;

    // Work registers; w_acc carries s32, then s17, then the checksum
    logic [15:0] w_len;
    logic [15:0] w_id;
    logic [15:0] w_seq;
    logic [31:0] w_acc;
    logic [15:0] timer;

    logic [31:0] s32;
    logic [16:0] s17;
    logic [15:0] chk;

    assign fifo_head = fifo_mem[rd_ptr];
    assign ctrl_busy = (state != S_IDLE);

    // Queue control and drop detection; a pop frees a slot for a same-cycle push
    always_comb begin
        push      = rx_sum_valid && p_valid;
        pop       = (state == S_IDLE) && (fifo_cnt != 2'd0);
        fifo_full = (fifo_cnt == 2'd2);
        push_ok   = push && (!fifo_full || pop);
        drop_inc  = (rx_pkt_done && p_valid && !rx_sum_valid) || (push && !push_ok);
    end

    // Checksum arithmetic for the three fold stages (type/code are zero)
    always_comb begin
        s32 = fifo_head[31:0] + {16'h0000, fifo_head[47:32]} + {16'h0000, fifo_head[63:48]};
        s17 = {1'b0, w_acc[31:16]} + {1'b0, w_acc[15:0]};
        chk = ~(w_acc[15:0] + {15'd0, w_acc[16]});
    end

    // Pending slot: a new header always wins; the old one is pushed first if its sum arrives now
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_valid <= 1'b0;
            p_len   <= 16'd0;
            p_id    <= 16'd0;
            p_seq   <= 16'd0;
        end else if (rx_pkt_done) begin
            p_valid <= 1'b1;
            p_len   <= rx_byte_num;
            p_id    <= rx_icmp_id;
            p_seq   <= rx_icmp_seq;
        end else if (push) begin
            p_valid <= 1'b0;
        end
    end

    // Descriptor queue storage and pointers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fifo_mem[0] <= 80'd0;
            fifo_mem[1] <= 80'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= {p_len, p_id, p_seq, rx_data_sum};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Saturating count of discarded requests
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt <= '0;
        end else if (drop_inc && (drop_cnt != CNT_MAX)) begin
            drop_cnt <= drop_cnt + CNT_ONE;
        end
    end

    // Reply FSM: fold checksum, wait for idle transmitter, start, supervise completion
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            w_len       <= 16'd0;
            w_id        <= 16'd0;
            w_seq       <= 16'd0;
            w_acc       <= 32'd0;
            timer       <= 16'd0;
            tx_start_en <= 1'b0;
            tx_byte_num <= 16'd0;
            tx_icmp_id  <= 16'd0;
            tx_icmp_seq <= 16'd0;
            tx_checksum <= 16'd0;
            timeout_cnt <= '0;
        end else begin
            tx_start_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        w_len <= fifo_head[79:64];
                        w_id  <= fifo_head[63:48];
                        w_seq <= fifo_head[47:32];
                        w_acc <= s32;
                        state <= S_FOLD1;
                    end
                end
                S_FOLD1: begin
                    w_acc <= {15'd0, s17};
                    state <= S_FOLD2;
                end
                S_FOLD2: begin
                    w_acc <= {16'h0000, chk};
                    state <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (!tx_busy) begin
                        tx_byte_num <= w_len;
                        tx_icmp_id  <= w_id;
                        tx_icmp_seq <= w_seq;
                        tx_checksum <= w_acc[15:0];
                        tx_start_en <= 1'b1;
                        timer       <= 16'd0;
                        state       <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_done) begin
                        state <= S_IDLE;
                    end else if (timer == TX_TIMEOUT - 16'd1) begin
                        if (timeout_cnt != CNT_MAX) begin
                            timeout_cnt <= timeout_cnt + CNT_ONE;
                        end
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icmp_echo_ctrl.sv
// tb/tb_icmp_echo_ctrl.sv - scoreboard bench for icmp_echo_ctrl
module tb_icmp_echo_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_pkt_done, rx_sum_valid;
    logic [15:0] rx_byte_num, rx_icmp_id, rx_icmp_seq;
    logic [31:0] rx_data_sum;
    logic        busy_force, resp_busy, resp_en, tx_done;
    logic        tx_busy;
    logic        tx_start_en, ctrl_busy;
    logic [15:0] tx_byte_num, tx_icmp_id, tx_icmp_seq, tx_checksum;
    logic [7:0]  drop_cnt, timeout_cnt;

    assign tx_busy = busy_force | resp_busy;

    always #5 clk = ~clk;

    icmp_echo_ctrl #(.TX_TIMEOUT(16'd16), .DROP_CNT_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .rx_pkt_done(rx_pkt_done), .rx_byte_num(rx_byte_num),
        .rx_icmp_id(rx_icmp_id), .rx_icmp_seq(rx_icmp_seq),
        .rx_sum_valid(rx_sum_valid), .rx_data_sum(rx_data_sum),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num),
        .tx_icmp_id(tx_icmp_id), .tx_icmp_seq(tx_icmp_seq),
        .tx_checksum(tx_checksum), .ctrl_busy(ctrl_busy),
        .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
    );

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] id;
        logic [15:0] seq;
        logic [15:0] chk;
    } rep_t;

    rep_t        sb[$];
    rep_t        mon_e;
    int          ncmp = 0;
    int          nerr = 0;
    int          start_cnt = 0;
    int          drop_exp = 0;
    int          tmo_exp = 0;
    bit          expect_full = 0;
    bit          m_pvalid = 0;
    logic [15:0] m_len, m_id, m_seq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One's-complement sum of the reply header words plus payload sum, folded until it fits
    function automatic logic [15:0] ref_chk(input logic [15:0] id, input logic [15:0] seq,
                                            input logic [31:0] sum);
        logic [31:0]     s;
        longint unsigned acc;
        s   = sum + {16'h0000, id} + {16'h0000, seq};
        acc = s;
        while (acc > 64'hFFFF) acc = (acc >> 16) + (acc & 64'hFFFF);
        return ~acc[15:0];
    endfunction

    // Drive one rx cycle from a negedge and update the reference model
    task automatic drive_cycle(input bit pd, input bit sv, input logic [15:0] len,
                               input logic [15:0] id, input logic [15:0] seq,
                               input logic [31:0] sum);
        rx_pkt_done  = pd;
        rx_sum_valid = sv;
        rx_byte_num  = len;
        rx_icmp_id   = id;
        rx_icmp_seq  = seq;
        rx_data_sum  = sum;
        if (sv && m_pvalid) begin
            if (expect_full) drop_exp++;
            else sb.push_back('{m_len, m_id, m_seq, ref_chk(m_id, m_seq, sum)});
            m_pvalid = 0;
        end
        if (pd) begin
            if (m_pvalid) drop_exp++;
            m_pvalid = 1;
            m_len = len; m_id = id; m_seq = seq;
        end
        @(negedge clk);
        rx_pkt_done  = 1'b0;
        rx_sum_valid = 1'b0;
    endtask

    task automatic send_req(input logic [15:0] len, input logic [15:0] id,
                            input logic [15:0] seq, input logic [31:0] sum);
        drive_cycle(1, 0, len, id, seq, 32'd0);
        drive_cycle(0, 1, 16'd0, 16'd0, 16'd0, sum);
    endtask

    task automatic wait_start(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!tx_start_en && cnt < 300);
        if (!tx_start_en) begin
            ncmp++; nerr++;
            $display("FAIL start_wait: no tx_start_en within %0d cycles", cnt);
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((sb.size() != 0 || ctrl_busy || tx_busy) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("drain_bound", {63'd0, c < 3000}, 64'd1);
    endtask

    // Monitor: every start must match the oldest expected reply
    always @(negedge clk) begin
        if (resetn && tx_start_en) begin
            start_cnt++;
            if (sb.size() == 0) begin
                ncmp++; nerr++;
                $display("FAIL unexpected_start: id %0h seq %0h with empty scoreboard",
                         tx_icmp_id, tx_icmp_seq);
            end else begin
                mon_e = sb.pop_front();
                check("reply", {tx_byte_num, tx_icmp_id, tx_icmp_seq, tx_checksum}, mon_e);
            end
        end
    end

    // Transmitter model: busy for a random time after each start, then a done pulse
    initial begin
        resp_busy = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && resetn && tx_start_en) begin
                resp_busy = 1'b1;
                repeat ($urandom_range(1, 8)) @(negedge clk);
                resp_busy = 1'b0;
                tx_done   = 1'b1;
                @(negedge clk);
                tx_done   = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        nerr++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, s0, mode, hold;
        logic [15:0] r_len, r_id, r_seq;
        logic [31:0] r_sum;
        resetn = 1'b0; busy_force = 1'b0; resp_en = 1'b1;
        rx_pkt_done = 0; rx_sum_valid = 0; rx_byte_num = 0;
        rx_icmp_id = 0; rx_icmp_seq = 0; rx_data_sum = 0;
        repeat (3) @(negedge clk);
        check("rst_start", {63'd0, tx_start_en}, 64'd0);
        check("rst_busy", {63'd0, ctrl_busy}, 64'd0);
        check("rst_fields", {tx_byte_num, tx_icmp_id, tx_icmp_seq, tx_checksum}, 64'd0);
        check("rst_drop", {56'd0, drop_cnt}, 64'd0);
        check("rst_tmo", {56'd0, timeout_cnt}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Basic reply and latency
        send_req(16'd32, 16'h0001, 16'h0005, 32'h0001_2345);
        wait_start(c);
        check("latency", c, 64'd4);
        check("chk_dcb3", {48'd0, tx_checksum}, 64'hDCB3);
        wait_drain();

        // Double carry, zero-length payload
        send_req(16'd0, 16'h0000, 16'h0000, 32'h0001_FFFF);
        wait_start(c);
        check("chk_fffe", {48'd0, tx_checksum}, 64'hFFFE);
        wait_drain();

        // Transmitter busy holds the reply; outputs keep previous values
        busy_force = 1'b1;
        s0 = start_cnt;
        send_req(16'd100, 16'hABCD, 16'h1234, $urandom);
        repeat (100) @(negedge clk);
        check("busy_no_start", s0, start_cnt);
        check("busy_hold", {tx_byte_num, tx_checksum}, {16'd0, 16'hFFFE});
        busy_force = 1'b0;
        wait_start(c);
        check("busy_release", c, 64'd1);
        wait_drain();

        // Four requests while the first is parked in WAIT_TX: fourth is dropped
        busy_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_full = (i == 3);
            send_req(16'(i + 1), 16'h0100 + 16'(i), 16'h0200 + 16'(i), $urandom);
        end
        expect_full = 0;
        check("full_drop", {56'd0, drop_cnt}, drop_exp);
        busy_force = 1'b0;
        wait_drain();

        // Header overwrite: reply carries the second descriptor
        drive_cycle(1, 0, 16'd10, 16'h1111, 16'h2222, 32'd0);
        drive_cycle(0, 0, 16'd0, 16'd0, 16'd0, 32'd0);
        drive_cycle(1, 0, 16'd20, 16'h3333, 16'h4444, 32'd0);
        drive_cycle(0, 1, 16'd0, 16'd0, 16'd0, 32'h0000_BEEF);
        wait_drain();
        check("overwrite_drop", {56'd0, drop_cnt}, drop_exp);

        // Same-cycle sum and new header, then a stray sum with nothing pending
        drive_cycle(1, 0, 16'd5, 16'h5555, 16'h6666, 32'd0);
        drive_cycle(1, 1, 16'd6, 16'h7777, 16'h8888, 32'h1234_5678);
        drive_cycle(0, 1, 16'd0, 16'd0, 16'd0, 32'h8765_4321);
        wait_drain();
        s0 = start_cnt;
        drive_cycle(0, 1, 16'd0, 16'd0, 16'd0, 32'hDEAD_BEEF);
        repeat (10) @(negedge clk);
        check("stray_sum", start_cnt, s0);
        check("same_cycle_drop", {56'd0, drop_cnt}, drop_exp);

        // Timeout when tx_done never arrives
        resp_en = 1'b0;
        send_req(16'd8, 16'h0A0A, 16'h0B0B, $urandom);
        wait_start(c);
        tmo_exp++;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (ctrl_busy && c < 100);
        check("timeout_idle", c, 64'd16);
        check("timeout_cnt", {56'd0, timeout_cnt}, tmo_exp);
        resp_en = 1'b1;
        send_req(16'd9, 16'h0C0C, 16'h0D0D, $urandom);
        wait_start(c);
        check("after_timeout_latency", c, 64'd4);
        wait_drain();

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 3);
            r_len = 16'($urandom); r_id = 16'($urandom);
            r_seq = 16'($urandom); r_sum = $urandom;
            hold = $urandom_range(0, 1);
            if (hold) busy_force = 1'b1;
            case (mode)
                0: send_req(r_len, r_id, r_seq, r_sum);
                1: begin
                    drive_cycle(1, 0, 16'($urandom), 16'($urandom), 16'($urandom), 32'd0);
                    send_req(r_len, r_id, r_seq, r_sum);
                end
                2: begin
                    drive_cycle(1, 0, r_len, r_id, r_seq, 32'd0);
                    drive_cycle(1, 1, ~r_len, ~r_id, ~r_seq, r_sum);
                    drive_cycle(0, 1, 16'd0, 16'd0, 16'd0, ~r_sum);
                end
                default: begin
                    drive_cycle(0, 1, 16'd0, 16'd0, 16'd0, $urandom);
                    send_req(r_len, r_id, r_seq, r_sum);
                end
            endcase
            if (hold) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                busy_force = 1'b0;
            end
            wait_drain();
        end
        check("rand_drop", {56'd0, drop_cnt}, drop_exp);
        check("rand_tmo", {56'd0, timeout_cnt}, tmo_exp);

        // Reset during WAIT_DONE with another request queued
        resp_en = 1'b0;
        send_req(16'd44, 16'h4444, 16'h4545, $urandom);
        wait_start(c);
        send_req(16'd55, 16'h5555, 16'h5656, $urandom);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_start", {63'd0, tx_start_en}, 64'd0);
        check("mid_rst_busy", {63'd0, ctrl_busy}, 64'd0);
        check("mid_rst_fields", {tx_byte_num, tx_icmp_id, tx_icmp_seq, tx_checksum}, 64'd0);
        check("mid_rst_cnts", {48'd0, drop_cnt, timeout_cnt}, 64'd0);
        sb.delete();
        m_pvalid = 0; drop_exp = 0; tmo_exp = 0;
        @(negedge clk);
        resetn = 1'b1;
        s0 = start_cnt;
        repeat (60) @(negedge clk);
        check("post_rst_no_start", start_cnt, s0);
        check("post_rst_idle", {63'd0, ctrl_busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
